button_irq_servicer: RTL
========================

# button_irq_servicer

Hardware servicer for the 4-bit button PIO: an Avalon-MM initiator that programs the PIO's interrupt mask, reacts to its `irq`, and reads and clears the edge-capture register. It also samples the current button levels and pushes each event into a small FIFO. Events leave on a valid/ready stream, so downstream logic consumes button presses without CPU involvement. It sits beside the button PIO in the system, replacing the Nios ISR path.

## Interface
- `WIDTH`, 4: button count; capture and level field width.
- `IRQ_MASK`, 4'hF: value written to PIO mask register after reset.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `m_address` out 2: PIO register address.
- `m_chipselect` out 1: access strobe, one cycle per access.
- `m_write_n` out 1: 0 = write.
- `m_writedata` out 32: write data.
- `m_readdata` in 32: PIO read data, registered by the PIO, valid the cycle after the read strobe.
- `irq_in` in 1: PIO interrupt, level.
- `ev_valid` out 1: FIFO head valid.
- `ev_ready` in 1: consumer accepts head.
- `ev_data` out 2*WIDTH: {level, capture}.
- `drop_count` out 8: saturating count of events lost to a full FIFO.
- `busy` out 1: FSM not in IDLE.

## Operation
- Register addresses: DATA=0, MASK=2, EDGE=3. The PIO has no waitrequest, and any write to EDGE clears all capture bits.
- FSM states: INIT, IDLE, RD_CAP, WAIT_CAP, CLR_CAP, RD_LVL, WAIT_LVL, PUSH.
- INIT: one write to MASK with `{28'b0, IRQ_MASK}` zero-extended, then go to IDLE. Executes exactly once per reset.
- IDLE: if `irq_in`=1, go to RD_CAP.
- RD_CAP: read strobe to EDGE.
- WAIT_CAP: latch `m_readdata[WIDTH-1:0]` into `cap`.
- CLR_CAP: write 0 to EDGE. If `cap`==0 (spurious), return to IDLE with no push.
- RD_LVL, then WAIT_LVL: read DATA and latch `lvl`.
- PUSH: enqueue `{lvl, cap}`, then go to IDLE. If the FIFO is full, drop the event and increment `drop_count`, saturating at 255.
- Edges arriving between the capture read and the clear are lost; this is accepted behaviour. Edges arriving after the clear re-raise `irq_in` and are serviced on the next pass.
- `m_chipselect` is 1 only in INIT, RD_CAP, CLR_CAP and RD_LVL. Otherwise `m_write_n`=1 and `m_writedata`=0.
- FIFO:
  - `ev_valid` = not empty; a pop occurs when `ev_valid && ev_ready`.
  - Simultaneous push and pop while full: the push is accepted and nothing is dropped.
  - Simultaneous push and pop while empty: the push is accepted; `ev_valid` rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- All outputs are registered.
- Reset values: `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0, `ev_valid`=0, `ev_data`=0, `drop_count`=0, `busy`=1 (INIT).
- The MASK write strobe occurs in the first cycle after reset deassertion.
- Service pass, from the first IDLE cycle with `irq_in`=1:
  - RD_CAP strobe at +1.
  - CLR_CAP strobe at +3.
  - RD_LVL strobe at +4.
  - Push at +6; `ev_valid` is visible at +7 if the FIFO was empty.
- The earliest next IDLE is +7. By then `irq_in` from the cleared PIO is already low.
- Reset mid-pass: the FSM returns to INIT, the FIFO empties, the partial event is discarded, and the mask is rewritten.

## Structure
- `button_svc_pkg` holds:
  - the FSM state enum;
  - ADDR_DATA/ADDR_MASK/ADDR_EDGE constants.
- Sub-module `button_event_fifo`: parameterised sync FIFO with a push/full/drop interface and a valid/ready pop side.
- The FSM and Avalon drive logic live in the top module.

## Test plan
- Reset release → one write, addr 2, data 0x0000000F, at cycle 1; afterwards `busy`=0 with no further strobes.
- PIO model registers bit1 edge with levels 0x2 → read 3, write 3 (data 0), read 0 at the specified offsets; `ev_data`=0x22, `ev_valid` at +7.
- `irq_in` pulse with capture 0 → read 3 and write 3 occur; no DATA read and no event is pushed.
- `ev_ready`=0, six events with FIFO_DEPTH=4 → four events held, `drop_count`=2; then draining yields them in order.
- FIFO full with `ev_ready`=1 during PUSH → no drop, count stays 4.
- `reset_n` low during WAIT_LVL → all outputs return to reset values, the FIFO is empty, and the mask write repeats after release.

Source files
------------

// File: rtl/button_svc_pkg.sv
// Shared types and PIO register map for the button interrupt servicer.
package button_svc_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_CAP,
        ST_WAIT_CAP,
        ST_CLR_CAP,
        ST_RD_LVL,
        ST_WAIT_LVL,
        ST_PUSH
    } svc_state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/button_event_fifo.sv
// Small synchronous event FIFO: push side drops (and counts) when full,
// pop side is a valid/ready stream with registered head data.
module button_event_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [DW-1:0] ev_data,
    output logic [7:0]    drop_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     valid_q, valid_d;
    logic [DW-1:0]            data_q, data_d;
    logic [7:0]               drop_q, drop_d;
    logic                     pop, full, push_ok;

    // Next-state: a pop frees a slot in the same cycle, so push while full
    // is accepted when the consumer is also popping.
    always_comb begin
        pop      = valid_q && ev_ready;
        full     = (count_q == (AW+1)'(DEPTH));
        push_ok  = push && (!full || pop);
        mem_d    = mem_q;
        if (push_ok)
            mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (!push_ok && pop)
            count_d = count_q - (AW+1)'(1);
        valid_d  = (count_d != '0);
        // Head is pre-selected from next-state storage so ev_data is a flop.
        data_d   = valid_d ? mem_d[rd_ptr_d] : '0;
        drop_d   = drop_q;
        if (push && !push_ok && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    // Storage, pointers, head register and drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            drop_q   <= drop_d;
        end
    end

    assign ev_valid   = valid_q;
    assign ev_data    = data_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/button_irq_servicer.sv
// Avalon-MM initiator that services the button PIO interrupt in hardware:
// programs the mask, reads/clears edge capture, samples levels, and queues
// {level, capture} events onto a valid/ready stream.
module button_irq_servicer
    import button_svc_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK   = 4'hF,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [1:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata,
    input  logic               irq_in,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [2*WIDTH-1:0] ev_data,
    output logic [7:0]         drop_count,
    output logic               busy
);
    svc_state_e       state_q, state_d;
    logic [WIDTH-1:0] cap_q, cap_d, lvl_q, lvl_d;
    logic             cs_q, cs_d, wn_q, wn_d, busy_q, busy_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      wd_q, wd_d;
    logic             push;

    // Bus strobes are registered alongside the transition into the state
    // that owns them, so each access appears for exactly one cycle.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        lvl_d   = lvl_q;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = '0;
        wd_d    = '0;
        case (state_q)
            ST_INIT: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_MASK;
                wd_d    = {{(32-WIDTH){1'b0}}, IRQ_MASK};
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (irq_in) begin
                    cs_d    = 1'b1;
                    addr_d  = ADDR_EDGE;
                    state_d = ST_RD_CAP;
                end
            end
            ST_RD_CAP:   state_d = ST_WAIT_CAP;
            ST_WAIT_CAP: begin
                cap_d   = m_readdata[WIDTH-1:0];
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_EDGE;
                state_d = ST_CLR_CAP;
            end
            ST_CLR_CAP: begin
                // Empty capture means a spurious interrupt: nothing to report.
                if (cap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cs_d    = 1'b1;
                    addr_d  = ADDR_DATA;
                    state_d = ST_RD_LVL;
                end
            end
            ST_RD_LVL:   state_d = ST_WAIT_LVL;
            ST_WAIT_LVL: begin
                lvl_d   = m_readdata[WIDTH-1:0];
                state_d = ST_PUSH;
            end
            ST_PUSH:     state_d = ST_IDLE;
            default:     state_d = ST_INIT;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, latched PIO values and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cap_q   <= '0;
            lvl_q   <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            addr_q  <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            lvl_q   <= lvl_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
        end
    end

    assign push         = (state_q == ST_PUSH);
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_address    = addr_q;
    assign m_writedata  = wd_q;
    assign busy         = busy_q;

    button_event_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  ({lvl_q, cap_q}),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .drop_count (drop_count)
    );

endmodule
